// File: rtl/bank_burst_queue_if.sv
// Handshake bundle between the front-end scheduler, one per-bank burst queue and the bank arbiter.
// The slave modport is the queue's view; the master modport drives pushes and Ready.
interface bank_burst_queue_if #(
   parameter int REQ_SIZE = 16,
   parameter int DEPTH    = 8
);
   logic                    push_valid;
   logic [REQ_SIZE-1:0]     push_data;
   logic                    push_ready;
   logic                    Valid;
   logic [REQ_SIZE-1:0]     Data_out;
   logic                    Ready;
   logic [$clog2(DEPTH):0]  count;

   modport master (
      output push_valid, push_data, Ready,
      input  push_ready, Valid, Data_out, count
   );

   modport slave (
      input  push_valid, push_data, Ready,
      output push_ready, Valid, Data_out, count
   );
endinterface

// File: rtl/bank_burst_queue.sv
// Per-bank request FIFO that releases entries to the bank arbiter in bursts of up to BURST_LEN.
// Optional macro PROTOCOL_CHK_EN adds the sticky err_proto output for Ready-without-Valid pulses.
module bank_burst_queue #(
   parameter int REQ_SIZE  = 16,
   parameter int DEPTH     = 8,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bank_burst_queue_if.slave       bus
`ifdef PROTOCOL_CHK_EN
   ,
   output logic                    err_proto
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int AGW = $clog2(TIMEOUT) + 1;
   localparam int BLW = $clog2(BURST_LEN) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AGW-1:0]       age_q, age_d;
   logic [BLW-1:0]       burst_left_q, burst_left_d;
   logic [REQ_SIZE-1:0]  mem_q [DEPTH];

   logic push_fire;
   logic pop_fire;

   assign bus.Valid      = (state_q == DRAIN);
   assign bus.push_ready = (count_q != CW'(DEPTH));
   assign bus.Data_out   = mem_q[rd_ptr_q];
   assign bus.count      = count_q;

   assign push_fire = bus.push_valid && bus.push_ready;
   assign pop_fire  = bus.Valid && bus.Ready;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_fire);
      rd_ptr_d = rd_ptr_q + AW'(pop_fire);
      count_d  = count_q + CW'(push_fire) - CW'(pop_fire);
   end

   always_comb begin
      state_d      = state_q;
      age_d        = age_q;
      burst_left_d = burst_left_q;
      case (state_q)
         IDLE: begin
            if (push_fire) begin
               state_d = COLLECT;
               age_d   = '0;
            end
         end
         COLLECT: begin
            age_d = age_q + AGW'(1);
            if ((count_q >= CW'(BURST_LEN)) || (age_q == AGW'(TIMEOUT - 1))) begin
               // Burst size is frozen from the pre-edge occupancy; later pushes wait.
               state_d      = DRAIN;
               age_d        = '0;
               burst_left_d = (count_q >= CW'(BURST_LEN)) ? BLW'(BURST_LEN) : BLW'(count_q);
            end
         end
         DRAIN: begin
            if (pop_fire) begin
               burst_left_d = burst_left_q - BLW'(1);
               if (burst_left_q == BLW'(1)) begin
                  state_d = (count_d != '0) ? COLLECT : IDLE;
                  age_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         age_q        <= '0;
         burst_left_q <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         age_q        <= age_d;
         burst_left_q <= burst_left_d;
      end
   end

   // Storage is deliberately left unreset; Data_out is only meaningful while Valid is high.
   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem_q[wr_ptr_q] <= bus.push_data;
      end
   end

`ifdef PROTOCOL_CHK_EN
   logic err_proto_q, err_proto_d;

   // Valid is always low in the cycle after a final pop, so this also flags over-consume.
   always_comb begin
      err_proto_d = err_proto_q | (bus.Ready & ~bus.Valid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_proto_q <= 1'b0;
      end else begin
         err_proto_q <= err_proto_d;
      end
   end

   assign err_proto = err_proto_q;
`endif

endmodule

// File: tb/tb_bank_burst_queue.sv
// Scoreboard bench for bank_burst_queue: directed scenarios followed by randomized traffic,
// with a negedge monitor comparing every pop and burst boundary against a queue-based model.
module tb_bank_burst_queue;
   localparam int REQ_SIZE  = 16;
   localparam int DEPTH     = 8;
   localparam int BURST_LEN = 4;
   localparam int TIMEOUT   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   bank_burst_queue_if #(.REQ_SIZE(REQ_SIZE), .DEPTH(DEPTH)) bus ();

`ifdef PROTOCOL_CHK_EN
   logic err_proto;
`endif

   bank_burst_queue #(
      .REQ_SIZE (REQ_SIZE),
      .DEPTH    (DEPTH),
      .BURST_LEN(BURST_LEN),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus)
`ifdef PROTOCOL_CHK_EN
      ,
      .err_proto(err_proto)
`endif
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   task automatic chk(input string name, input bit ok, input longint act, input longint req);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Reference model: contents of the queue plus burst bookkeeping derived from the rules.
   logic [REQ_SIZE-1:0] model[$];
   int  sz, size_prev, lowrun, pops_run, burst_exp;
   bit  prev_valid, must_rise;

   always @(negedge clk) begin
      if (!rst_n) begin
         model.delete();
         size_prev  = 0;
         lowrun     = 0;
         pops_run   = 0;
         burst_exp  = 0;
         prev_valid = 1'b0;
         must_rise  = 1'b0;
      end else begin
         sz = model.size();
         chk("count", bus.count == sz, bus.count, sz);
         chk("push_ready", bus.push_ready == (sz != DEPTH), bus.push_ready, sz != DEPTH);
         if (must_rise) chk("full_burst_latency", bus.Valid == 1'b1, bus.Valid, 1);
         if (bus.Valid) begin
            if (!prev_valid) begin
               chk("gap_min", lowrun >= 1, lowrun, 1);
               burst_exp = (size_prev < BURST_LEN) ? size_prev : BURST_LEN;
               pops_run  = 0;
            end
            chk("burst_limit", pops_run < burst_exp, pops_run, burst_exp);
         end else if (prev_valid) begin
            chk("burst_len", pops_run == burst_exp, pops_run, burst_exp);
         end
         lowrun = (!bus.Valid && sz > 0) ? lowrun + 1 : 0;
         if (!bus.Valid && sz > 0) chk("collect_timeout", lowrun <= TIMEOUT, lowrun, TIMEOUT);
         must_rise = !bus.Valid && (sz >= BURST_LEN);
         if (bus.Valid && bus.Ready) begin
            if (sz == 0) begin
               chk("pop_empty", 1'b0, bus.Data_out, 0);
            end else begin
               chk("pop_data", bus.Data_out == model[0], bus.Data_out, model[0]);
               void'(model.pop_front());
            end
            pops_run++;
         end
         if (bus.push_valid && sz != DEPTH) model.push_back(bus.push_data);
         size_prev  = sz;
         prev_valid = bus.Valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      int pv_prob;
      int rd_prob;
      logic [REQ_SIZE-1:0] last;

      bus.push_valid = 1'b0;
      bus.push_data  = '0;
      bus.Ready      = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state and ignored Ready while idle
      chk("rst_valid", bus.Valid == 1'b0, bus.Valid, 0);
      chk("rst_count", bus.count == 0, bus.count, 0);
      chk("rst_push_ready", bus.push_ready == 1'b1, bus.push_ready, 1);
`ifdef PROTOCOL_CHK_EN
      chk("rst_err_proto", err_proto == 1'b0, err_proto, 0);
`endif
      rst_n = 1'b1;
      cyc();
      bus.Ready = 1'b1;
      repeat (5) cyc();
      bus.Ready = 1'b0;
      chk("idle_ready_valid", bus.Valid == 1'b0, bus.Valid, 0);
      chk("idle_ready_count", bus.count == 0, bus.count, 0);
`ifdef PROTOCOL_CHK_EN
      chk("err_proto_set", err_proto == 1'b1, err_proto, 1);
      reset_dut();
      chk("err_proto_clear", err_proto == 1'b0, err_proto, 0);
`endif

      // Full burst of four
      for (int i = 0; i < 4; i++) begin
         bus.push_valid = 1'b1;
         bus.push_data  = REQ_SIZE'(16'h0A01 + i);
         cyc();
      end
      bus.push_valid = 1'b0;
      chk("t2_count", bus.count == 4, bus.count, 4);
      chk("t2_valid_low", bus.Valid == 1'b0, bus.Valid, 0);
      cyc();
      chk("t2_valid_rise", bus.Valid == 1'b1, bus.Valid, 1);
      bus.Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_data", bus.Data_out == REQ_SIZE'(16'h0A01 + i), bus.Data_out, 16'h0A01 + i);
         cyc();
      end
      bus.Ready = 1'b0;
      chk("t2_valid_end", bus.Valid == 1'b0, bus.Valid, 0);
      chk("t2_count_end", bus.count == 0, bus.count, 0);

      // Partial burst released by timeout
      bus.Ready      = 1'b1;
      bus.push_valid = 1'b1;
      bus.push_data  = 16'h0C01;
      cyc();
      lat = 0;
      bus.push_data = 16'h0C02;
      cyc();
      lat++;
      bus.push_valid = 1'b0;
      while (!bus.Valid && lat < 40) begin
         cyc();
         lat++;
      end
      chk("t3_latency", lat == TIMEOUT, lat, TIMEOUT);
      chk("t3_data0", bus.Data_out == 16'h0C01, bus.Data_out, 16'h0C01);
      cyc();
      chk("t3_data1", bus.Data_out == 16'h0C02, bus.Data_out, 16'h0C02);
      cyc();
      chk("t3_valid_end", bus.Valid == 1'b0, bus.Valid, 0);
      chk("t3_count_end", bus.count == 0, bus.count, 0);
      bus.Ready = 1'b0;

      // Full queue back-pressure
      for (int i = 0; i < 8; i++) begin
         bus.push_valid = 1'b1;
         bus.push_data  = REQ_SIZE'(16'h0400 + i);
         cyc();
      end
      bus.push_data = 16'hBEEF;
      chk("t4_full_ready", bus.push_ready == 1'b0, bus.push_ready, 0);
      chk("t4_full_count", bus.count == 8, bus.count, 8);
      cyc();
      chk("t4_held_count", bus.count == 8, bus.count, 8);
      chk("t4_valid", bus.Valid == 1'b1, bus.Valid, 1);
      bus.Ready = 1'b1;
      cyc();
      bus.Ready = 1'b0;
      chk("t4_ready_back", bus.push_ready == 1'b1, bus.push_ready, 1);
      chk("t4_count7", bus.count == 7, bus.count, 7);
      cyc();
      bus.push_valid = 1'b0;
      chk("t4_beef_in", bus.count == 8, bus.count, 8);
      bus.Ready = 1'b1;
      last = '0;
      n = 0;
      while (bus.count != 0 && n < 200) begin
         if (bus.Valid) last = bus.Data_out;
         cyc();
         n++;
      end
      bus.Ready = 1'b0;
      chk("t4_drained", bus.count == 0, bus.count, 0);
      chk("t4_last", last == 16'hBEEF, last, 16'hBEEF);

      // Push during drain keeps occupancy and does not extend the burst
      for (int i = 0; i < 6; i++) begin
         bus.push_valid = 1'b1;
         bus.push_data  = REQ_SIZE'(16'h0500 + i);
         cyc();
      end
      chk("t5_valid", bus.Valid == 1'b1, bus.Valid, 1);
      bus.Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.push_data = REQ_SIZE'(16'h0510 + i);
         cyc();
         chk("t5_count", bus.count == 6, bus.count, 6);
      end
      bus.push_valid = 1'b0;
      chk("t5_gap", bus.Valid == 1'b0, bus.Valid, 0);
      cyc();
      chk("t5_second", bus.Valid == 1'b1, bus.Valid, 1);
      chk("t5_second_head", bus.Data_out == 16'h0504, bus.Data_out, 16'h0504);
      n = 0;
      while (bus.count != 0 && n < 200) begin
         cyc();
         n++;
      end
      bus.Ready = 1'b0;
      chk("t5_drained", bus.count == 0, bus.count, 0);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 4; i++) begin
         bus.push_valid = 1'b1;
         bus.push_data  = REQ_SIZE'(16'h0600 + i);
         cyc();
      end
      bus.push_valid = 1'b0;
      n = 0;
      while (!bus.Valid && n < 20) begin
         cyc();
         n++;
      end
      chk("t6_valid", bus.Valid == 1'b1, bus.Valid, 1);
      bus.Ready = 1'b1;
      cyc();
      cyc();
      rst_n     = 1'b0;
      bus.Ready = 1'b0;
      #1;
      chk("t6_async_valid", bus.Valid == 1'b0, bus.Valid, 0);
      chk("t6_async_count", bus.count == 0, bus.count, 0);
      chk("t6_async_ready", bus.push_ready == 1'b1, bus.push_ready, 1);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
`ifdef PROTOCOL_CHK_EN
      chk("t6_err_clear", err_proto == 1'b0, err_proto, 0);
      bus.Ready = 1'b1;
      cyc();
      bus.Ready = 1'b0;
      chk("t6_err_set", err_proto == 1'b1, err_proto, 1);
      repeat (3) cyc();
      chk("t6_err_sticky", err_proto == 1'b1, err_proto, 1);
      reset_dut();
      chk("t6_err_reset", err_proto == 1'b0, err_proto, 0);
`endif

      // Randomized traffic with shifting push/Ready densities
      pv_prob = 50;
      rd_prob = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 300 == 0) begin
            pv_prob = $urandom_range(10, 90);
            rd_prob = $urandom_range(10, 100);
         end
         bus.push_valid = ($urandom_range(0, 99) < pv_prob);
         bus.push_data  = REQ_SIZE'($urandom);
         bus.Ready      = ($urandom_range(0, 99) < rd_prob);
         cyc();
      end
      bus.push_valid = 1'b0;
      bus.Ready      = 1'b1;
      n = 0;
      while (bus.count != 0 && n < 200) begin
         cyc();
         n++;
      end
      bus.Ready = 1'b0;
      chk("rand_drained", bus.count == 0, bus.count, 0);
      cyc();
      chk("rand_idle_valid", bus.Valid == 1'b0, bus.Valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
